axi_ifetch_buffer: RTL and testbench

Parametrised instruction-fetch front end that replaces the single-word fetch path. It issues INCR bursts on the AXI read channels, unpacks each DATA_WIDTH beat into 32-bit instructions, and buffers them in a DEPTH-entry queue with a valid/ready output to decode. It also supports PC redirect with flush and in-flight burst drain. It sits between the bus interface of `top` and the decoder/control path.

---
 rtl/axi_ifetch_buffer.sv | 203 ++++++++++++++++++++
 tb/tb_axi_ifetch_buffer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_ifetch_buffer.sv
// Instruction-fetch front end: issues AXI INCR read bursts, unpacks each beat into
// 32-bit instructions and queues them for decode, with redirect/flush and burst drain.
module axi_ifetch_buffer #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH   = 13,
    parameter int BURST_LEN  = 4,
    parameter int DEPTH      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] entry,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic [ID_WIDTH-1:0]   m_axi_arid,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready,
    output logic                  if_valid,
    input  logic                  if_ready,
    output logic [31:0]           if_instr,
    output logic [ADDR_WIDTH-1:0] if_pc,
    output logic                  if_fault
);
    localparam int IPB        = DATA_WIDTH / 32;
    localparam int BYTES      = DATA_WIDTH / 8;
    localparam int OFFW       = $clog2(BYTES);
    localparam int SKW        = $clog2(IPB);
    localparam int PW         = $clog2(DEPTH);
    localparam int PAGE_BEATS = 4096 / BYTES;

    typedef enum logic [1:0] {S_ADDR, S_DATA, S_DRAIN, S_WAIT} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic                  arvalid_q, arvalid_d;
    logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
    logic [7:0]            arlen_q, arlen_d;
    logic                  drain_pend_q, drain_pend_d;
    logic                  first_q, first_d;
    logic [ADDR_WIDTH-1:0] beat_addr_q, beat_addr_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0]           count_q, count_d;

    logic [31:0]           q_instr [DEPTH];
    logic [ADDR_WIDTH-1:0] q_pc    [DEPTH];
    logic                  q_fault [DEPTH];

    logic [31:0]           word_data [IPB];
    logic [ADDR_WIDTH-1:0] word_pc   [IPB];

    logic                  push_en, pop_en, load_req, room;
    logic [SKW-1:0]        skip;
    logic [PW:0]           push_n;
    logic [ADDR_WIDTH-1:0] tgt_pc, burst_end;
    logic [31:0]           page_beats, beats, need, free_cnt;

    genvar gi;
    generate
        for (gi = 0; gi < IPB; gi++) begin : g_word
            assign word_data[gi] = m_axi_rdata[gi*32 +: 32];
            assign word_pc[gi]   = beat_addr_q + ADDR_WIDTH'(gi * 4);
        end
    endgenerate

    // Only the first beat of a burst can start below fetch_pc; skipped words are a prefix.
    assign skip     = first_q ? fetch_pc_q[OFFW-1:2] : '0;
    assign push_en  = (state_q == S_DATA) && m_axi_rvalid && !redirect_valid;
    assign push_n   = push_en ? ((PW+1)'(IPB) - (PW+1)'(skip)) : '0;
    assign pop_en   = (count_q != '0) && if_ready && !redirect_valid;
    assign count_d  = redirect_valid ? '0 : (count_q + push_n - (PW+1)'(pop_en));
    assign wr_ptr_d = redirect_valid ? '0 : (wr_ptr_q + push_n[PW-1:0]);
    assign rd_ptr_d = redirect_valid ? '0 : (rd_ptr_q + PW'(pop_en));
    assign burst_end = araddr_q + ADDR_WIDTH'((32'(arlen_q) + 32'd1) * 32'(BYTES));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_ADDR;
            fetch_pc_q   <= entry;
            arvalid_q    <= 1'b0;
            araddr_q     <= '0;
            arlen_q      <= '0;
            drain_pend_q <= 1'b0;
            first_q      <= 1'b0;
            beat_addr_q  <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            arvalid_q    <= arvalid_d;
            araddr_q     <= araddr_d;
            arlen_q      <= arlen_d;
            drain_pend_q <= drain_pend_d;
            first_q      <= first_d;
            beat_addr_q  <= beat_addr_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < IPB; k++) begin
            if (push_en && (k >= int'(skip))) begin
                q_instr[wr_ptr_q + PW'(k - int'(skip))] <= word_data[k];
                q_pc[wr_ptr_q + PW'(k - int'(skip))]    <= word_pc[k];
                q_fault[wr_ptr_q + PW'(k - int'(skip))] <= (m_axi_rresp != 2'b00);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = redirect_valid ? redirect_pc : fetch_pc_q;
        arvalid_d    = arvalid_q;
        araddr_d     = araddr_q;
        arlen_d      = arlen_q;
        drain_pend_d = drain_pend_q;
        first_d      = first_q;
        beat_addr_d  = beat_addr_q;
        load_req     = 1'b0;
        tgt_pc       = redirect_valid ? redirect_pc : fetch_pc_q;
        case (state_q)
            S_ADDR: begin
                if (!arvalid_q) begin
                    load_req = 1'b1;
                end else begin
                    if (redirect_valid) drain_pend_d = 1'b1;
                    // A redirect cannot retract an AR already offered; its data is drained.
                    if (m_axi_arready) begin
                        arvalid_d    = 1'b0;
                        beat_addr_d  = araddr_q;
                        first_d      = 1'b1;
                        drain_pend_d = 1'b0;
                        state_d      = (redirect_valid || drain_pend_q) ? S_DRAIN : S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (m_axi_rvalid) begin
                    beat_addr_d = beat_addr_q + ADDR_WIDTH'(BYTES);
                    first_d     = 1'b0;
                    if (m_axi_rlast) begin
                        load_req = 1'b1;
                        if (!redirect_valid) tgt_pc = burst_end;
                    end else if (redirect_valid) begin
                        state_d = S_DRAIN;
                    end
                end else if (redirect_valid) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (m_axi_rvalid && m_axi_rlast) load_req = 1'b1;
            end
            default: begin
                load_req = 1'b1;
            end
        endcase

        page_beats = 32'(PAGE_BEATS) - 32'(tgt_pc[11:OFFW]);
        beats      = (page_beats < 32'(BURST_LEN)) ? page_beats : 32'(BURST_LEN);
        need       = beats * 32'(IPB);
        free_cnt   = 32'(DEPTH) - 32'(count_d);
        room       = (need <= free_cnt);
        if (load_req) begin
            fetch_pc_d = tgt_pc;
            if (room) begin
                state_d   = S_ADDR;
                arvalid_d = 1'b1;
                araddr_d  = {tgt_pc[ADDR_WIDTH-1:OFFW], OFFW'(0)};
                arlen_d   = 8'(beats - 32'd1);
            end else begin
                state_d = S_WAIT;
            end
        end
    end

    always_comb begin
        m_axi_rready = (state_q == S_DATA) || (state_q == S_DRAIN);
    end

    assign m_axi_arid    = '0;
    assign m_axi_araddr  = araddr_q;
    assign m_axi_arlen   = arlen_q;
    assign m_axi_arsize  = 3'(OFFW);
    assign m_axi_arburst = 2'b01;
    assign m_axi_arvalid = arvalid_q;
    assign if_valid      = (count_q != '0);
    assign if_instr      = q_instr[rd_ptr_q];
    assign if_pc         = q_pc[rd_ptr_q];
    assign if_fault      = q_fault[rd_ptr_q];
endmodule

// File: tb/tb_axi_ifetch_buffer.sv
// Scoreboard bench for axi_ifetch_buffer: directed fetch scenarios against a simple AXI
// read slave whose memory word at address A holds A[31:0] ^ 32'h5A5A5A5A.
module tb_axi_ifetch_buffer;
    localparam int AW = 64, DW = 64, IDW = 13, BL = 4, DEP = 16;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [AW-1:0]  entry = '0;
    logic           redirect_valid = 1'b0;
    logic [AW-1:0]  redirect_pc = '0;
    logic [IDW-1:0] m_axi_arid;
    logic [AW-1:0]  m_axi_araddr;
    logic [7:0]     m_axi_arlen;
    logic [2:0]     m_axi_arsize;
    logic [1:0]     m_axi_arburst;
    logic           m_axi_arvalid;
    logic           m_axi_arready = 1'b0;
    logic [DW-1:0]  m_axi_rdata = '0;
    logic [1:0]     m_axi_rresp = '0;
    logic           m_axi_rlast = 1'b0;
    logic           m_axi_rvalid = 1'b0;
    logic           m_axi_rready;
    logic           if_valid;
    logic           if_ready = 1'b1;
    logic [31:0]    if_instr;
    logic [AW-1:0]  if_pc;
    logic           if_fault;

    axi_ifetch_buffer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IDW),
                        .BURST_LEN(BL), .DEPTH(DEP)) dut (
        .clk(clk), .reset(reset), .entry(entry),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
        .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
        .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr),
        .if_pc(if_pc), .if_fault(if_fault)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    typedef struct { logic [63:0] pc; logic [31:0] instr; logic fault; } if_exp_t;
    typedef struct { logic [63:0] addr; logic [7:0] len; } ar_exp_t;
    if_exp_t exp_if[$];
    ar_exp_t exp_ar[$];

    int ar_budget = 0, ar_total = 0, r_total = 0, r_stall = 0, fault_beat = -1;
    logic [63:0] bq_addr[$];
    int          bq_len[$];
    int          cur_beat = 0;

    function automatic logic [31:0] winstr(logic [63:0] a);
        return a[31:0] ^ 32'h5A5A_5A5A;
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_if(logic [63:0] pc0, int n, int fault_lo, int fault_hi);
        if_exp_t e;
        for (int i = 0; i < n; i++) begin
            e.pc    = pc0 + 64'(4 * i);
            e.instr = winstr(e.pc);
            e.fault = (i >= fault_lo) && (i <= fault_hi);
            exp_if.push_back(e);
        end
    endtask

    task automatic push_ar(logic [63:0] a, logic [7:0] l);
        ar_exp_t e;
        e.addr = a;
        e.len  = l;
        exp_ar.push_back(e);
    endtask

    // AXI read slave: handshakes are observed at negedge and take effect after the posedge.
    always begin : slave_p
        logic ar_hs, r_hs;
        logic [63:0] a, ba;
        logic [7:0] l;
        @(negedge clk);
        ar_hs = m_axi_arvalid && m_axi_arready && !reset;
        r_hs  = m_axi_rvalid && m_axi_rready && !reset;
        if (!reset && m_axi_rvalid && !m_axi_rready) r_stall++;
        a = m_axi_araddr;
        l = m_axi_arlen;
        @(posedge clk);
        #1;
        if (reset) begin
            bq_addr.delete();
            bq_len.delete();
            cur_beat = 0;
            r_total  = 0;
            ar_total = 0;
        end else begin
            if (r_hs) begin
                r_total++;
                if (cur_beat == bq_len[0]) begin
                    void'(bq_addr.pop_front());
                    void'(bq_len.pop_front());
                    cur_beat = 0;
                end else begin
                    cur_beat++;
                end
            end
            if (ar_hs) begin
                bq_addr.push_back(a);
                bq_len.push_back(int'(l));
                ar_budget--;
                ar_total++;
            end
        end
        m_axi_arready = (ar_budget > 0) && !reset;
        if (bq_addr.size() > 0) begin
            ba           = bq_addr[0] + 64'(cur_beat * 8);
            m_axi_rdata  = {winstr(ba + 64'd4), winstr(ba)};
            m_axi_rlast  = (cur_beat == bq_len[0]);
            m_axi_rresp  = (r_total == fault_beat) ? 2'b10 : 2'b00;
            m_axi_rvalid = 1'b1;
        end else begin
            m_axi_rdata  = '0;
            m_axi_rlast  = 1'b0;
            m_axi_rresp  = 2'b00;
            m_axi_rvalid = 1'b0;
        end
    end

    always @(negedge clk) begin : if_mon
        if_exp_t e;
        if (!reset && if_valid && if_ready && !redirect_valid) begin
            $display("pop  pc=0x%0h instr=0x%08h fault=%0b", if_pc, if_instr, if_fault);
            if (exp_if.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL if_unexpected: got pc 0x%0h, expected no instruction", if_pc);
            end else begin
                e = exp_if.pop_front();
                check("if_pc", if_pc, e.pc);
                check("if_instr", 64'(if_instr), 64'(e.instr));
                check("if_fault", 64'(if_fault), 64'(e.fault));
            end
        end
    end

    always @(negedge clk) begin : ar_mon
        ar_exp_t e;
        if (!reset && m_axi_arvalid && m_axi_arready) begin
            $display("ar   addr=0x%0h len=%0d", m_axi_araddr, m_axi_arlen);
            if (exp_ar.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL ar_unexpected: got araddr 0x%0h, expected no AR", m_axi_araddr);
            end else begin
                e = exp_ar.pop_front();
                check("araddr", m_axi_araddr, e.addr);
                check("arlen", 64'(m_axi_arlen), 64'(e.len));
                check("arsize", 64'(m_axi_arsize), 64'd3);
                check("arburst", 64'(m_axi_arburst), 64'd1);
                check("arid", 64'(m_axi_arid), 64'd0);
            end
        end
    end

    task automatic start_test(logic [63:0] e, int budget, int fb);
        @(posedge clk);
        #2;
        reset          = 1'b1;
        entry          = e;
        ar_budget      = budget;
        fault_beat     = fb;
        redirect_valid = 1'b0;
        r_stall        = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_arvalid", 64'(m_axi_arvalid), 64'd0);
        check("rst_rready", 64'(m_axi_rready), 64'd0);
        check("rst_if_valid", 64'(if_valid), 64'd0);
        check("rst_araddr", m_axi_araddr, 64'd0);
        check("rst_arlen", 64'(m_axi_arlen), 64'd0);
        @(posedge clk);
        #2;
        reset = 1'b0;
    endtask

    task automatic end_test(int cycles);
        repeat (cycles) @(posedge clk);
        #2;
        check("ar_left", 64'(exp_ar.size()), 64'd0);
        check("if_left", 64'(exp_if.size()), 64'd0);
        check("r_stall", 64'(r_stall), 64'd0);
        exp_ar.delete();
        exp_if.delete();
    endtask

    initial begin
        // Aligned entry: one 4-beat burst, eight instructions in order.
        if_ready = 1'b1;
        push_ar(64'h8000_0000, 8'd3);
        push_if(64'h8000_0000, 8, -1, -1);
        start_test(64'h8000_0000, 1, -1);
        end_test(40);

        // Misaligned entry drops the low word of the first beat.
        push_ar(64'h8000_0000, 8'd3);
        push_if(64'h8000_0004, 7, -1, -1);
        start_test(64'h8000_0004, 1, -1);
        end_test(40);

        // Burst shortened at the 4 KB boundary, then a full burst on the next page.
        push_ar(64'h8000_0FF0, 8'd1);
        push_ar(64'h8000_1000, 8'd3);
        push_if(64'h8000_0FF0, 4, -1, -1);
        push_if(64'h8000_1000, 8, -1, -1);
        start_test(64'h8000_0FF0, 2, -1);
        end_test(50);

        // Back-pressure: two bursts fill the queue, third AR waits for 8 pops.
        if_ready = 1'b0;
        push_ar(64'h8000_0000, 8'd3);
        push_ar(64'h8000_0020, 8'd3);
        push_ar(64'h8000_0040, 8'd3);
        push_if(64'h8000_0000, 24, -1, -1);
        start_test(64'h8000_0000, 3, -1);
        repeat (60) @(posedge clk);
        #2;
        check("bp_ar_count", 64'(ar_total), 64'd2);
        check("bp_if_valid", 64'(if_valid), 64'd1);
        if_ready = 1'b1;
        end_test(80);

        // Redirect after beat 1: remaining beats drained, fetch restarts at the new PC.
        if_ready = 1'b0;
        push_ar(64'h8000_0000, 8'd3);
        push_ar(64'h8000_0200, 8'd3);
        push_if(64'h8000_0200, 8, -1, -1);
        start_test(64'h8000_0000, 2, -1);
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #2;
            if (r_total >= 2) break;
        end
        check("rd_beat_wait", 64'(r_total >= 2), 64'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_0200;
        @(posedge clk);
        #2;
        redirect_valid = 1'b0;
        if_ready       = 1'b1;
        end_test(60);

        // Error response on beat 1 marks exactly its two instructions.
        push_ar(64'h8000_0000, 8'd3);
        push_if(64'h8000_0000, 8, 2, 3);
        start_test(64'h8000_0000, 1, 1);
        end_test(40);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
